// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// Turns hazard-detector stall requests and memory handshakes into per-stage
// stall/flush controls for a 5-stage MIPS pipeline. A small FSM tracks how long
// the pipeline has been stalled back-to-back and latches a sticky watchdog
// error on lock-up; two saturating counters record stall and flush activity.
module hazard_sequencer #(
    parameter int CW        = 16,
    parameter int MAX_STALL = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          branch_stall,
    input  logic          lw_stall,
    input  logic          PCSrcD,
    input  logic          JumpD,
    input  logic          imem_ready,
    input  logic          dmem_ready,
    input  logic          count_clr,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          StallM,
    output logic          FlushD,
    output logic          FlushE,
    output logic          FlushW,
    output logic [CW-1:0] stall_cycles,
    output logic [CW-1:0] flush_count,
    output logic          watchdog_err
);

    localparam int RW = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;
    localparam logic [RW-1:0] RUN_LAST = RW'(MAX_STALL - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MEMW = 2'd1,
        ST_HAZ  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [RW-1:0]   run_len_r;
    logic [RW-1:0]   run_len_next_s;
    logic [CW-1:0]   stall_cycles_r;
    logic [CW-1:0]   flush_count_r;

    logic            freeze_s;
    logic            haz_s;
    logic            xfer_s;
    logic            stall_s;
    logic            in_err_s;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CW'(1);
        end
        return r;
    endfunction

    assign freeze_s = ~imem_ready | ~dmem_ready;
    assign haz_s    = branch_stall | lw_stall;
    assign xfer_s   = PCSrcD | JumpD;
    assign stall_s  = freeze_s | haz_s;
    assign in_err_s = (state_r == ST_ERR);

    // Stage controls by priority: error lock-up, memory freeze, hazard, control transfer.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (in_err_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (freeze_s) begin
            // Whole pipe holds; MEM/WB gets a bubble so nothing retires twice.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (haz_s) begin
            // Hold F/D and inject a bubble into E; a taken branch is re-evaluated
            // next cycle, so FlushD must stay low here.
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (xfer_s) begin
            FlushD = 1'b1;
        end else begin
            FlushD = 1'b0;
        end
    end

    // Next FSM state and consecutive-stall length.
    always_comb begin
        state_next_s   = state_r;
        run_len_next_s = run_len_r;
        case (state_r)
            ST_ERR: begin
                state_next_s   = ST_ERR;
                run_len_next_s = run_len_r;
            end
            ST_RUN, ST_MEMW, ST_HAZ: begin
                if (stall_s && (run_len_r == RUN_LAST)) begin
                    state_next_s   = ST_ERR;
                    run_len_next_s = run_len_r;
                end else if (freeze_s) begin
                    state_next_s   = ST_MEMW;
                    run_len_next_s = run_len_r + RW'(1);
                end else if (haz_s) begin
                    state_next_s   = ST_HAZ;
                    run_len_next_s = run_len_r + RW'(1);
                end else begin
                    state_next_s   = ST_RUN;
                    run_len_next_s = {RW{1'b0}};
                end
            end
            default: begin
                state_next_s   = ST_RUN;
                run_len_next_s = {RW{1'b0}};
            end
        endcase
    end

    // FSM state and run-length registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_RUN;
            run_len_r <= {RW{1'b0}};
        end else begin
            state_r   <= state_next_s;
            run_len_r <= run_len_next_s;
        end
    end

    // Saturating performance counters; frozen while locked up, clear beats increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_r <= {CW{1'b0}};
            flush_count_r  <= {CW{1'b0}};
        end else if (in_err_s) begin
            stall_cycles_r <= stall_cycles_r;
            flush_count_r  <= flush_count_r;
        end else if (count_clr) begin
            stall_cycles_r <= {CW{1'b0}};
            flush_count_r  <= {CW{1'b0}};
        end else begin
            stall_cycles_r <= StallF ? sat_inc(stall_cycles_r) : stall_cycles_r;
            flush_count_r  <= FlushD ? sat_inc(flush_count_r)  : flush_count_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;
    assign watchdog_err = in_err_s;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: a behavioural model predicts every
// cycle's outputs, a monitor compares them against the DUT at the falling edge.
module tb_hazard_sequencer;

    localparam int CW        = 3;
    localparam int MAX_STALL = 4;
    localparam int SAT       = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          branch_stall, lw_stall, PCSrcD, JumpD;
    logic          imem_ready, dmem_ready, count_clr;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [CW-1:0] stall_cycles, flush_count;
    logic          watchdog_err;

    hazard_sequencer #(.CW(CW), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .reset_n(reset_n),
        .branch_stall(branch_stall), .lw_stall(lw_stall),
        .PCSrcD(PCSrcD), .JumpD(JumpD),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .count_clr(count_clr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .watchdog_err(watchdog_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    ctl;   // StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,watchdog_err
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state
    bit m_err;
    int m_run;   // consecutive stall cycles seen so far
    int m_sc;
    int m_fc;

    task automatic model_reset();
        m_err = 1'b0;
        m_run = 0;
        m_sc  = 0;
        m_fc  = 0;
    endtask

    // Drive one cycle of inputs, predict the outputs, then advance the model over the edge.
    task automatic step(input bit rn, input bit bs, input bit lw, input bit pc, input bit j,
                        input bit im, input bit dm, input bit clr);
        exp_t e;
        bit   frz, hz, sf, sd, se, sm, fd, fe, fw;
        @(posedge clk);
        #1;
        reset_n = rn; branch_stall = bs; lw_stall = lw; PCSrcD = pc; JumpD = j;
        imem_ready = im; dmem_ready = dm; count_clr = clr;
        if (!rn) model_reset();
        frz = !im || !dm;
        hz  = bs || lw;
        {sf, sd, se, sm, fd, fe, fw} = 7'b0;
        if (m_err)      {sf, sd, se, sm, fd, fe, fw} = 7'b1111011;
        else if (frz)   {sf, sd, se, sm, fd, fe, fw} = 7'b1111001;
        else if (hz)    {sf, sd, se, sm, fd, fe, fw} = 7'b1100010;
        else if (pc||j) {sf, sd, se, sm, fd, fe, fw} = 7'b0000100;
        e.ctl = {sf, sd, se, sm, fd, fe, fw, m_err};
        e.sc  = CW'(m_sc);
        e.fc  = CW'(m_fc);
        e.cyc = cyc;
        exp_q.push_back(e);
        cyc++;
        if (rn && !m_err) begin
            if (clr) begin
                m_sc = 0;
                m_fc = 0;
            end else begin
                if (sf) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
                if (fd) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
            end
            if (frz || hz) begin
                m_run++;
                if (m_run >= MAX_STALL) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 1, 1, 0);
    endtask

    // Monitor: every falling edge the DUT presents a full set of outputs to compare.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = exp_q.pop_front();
            act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, watchdog_err};
            checks++;
            if (act !== e.ctl || stall_cycles !== e.sc || flush_count !== e.fc) begin
                errors++;
                $display("FAIL cycle%0d: ctl/sc/fc got %b/%0d/%0d expected %b/%0d/%0d",
                         e.cyc, act, stall_cycles, flush_count, e.ctl, e.sc, e.fc);
            end
        end
    end

    initial begin
        reset_n = 1'b0; branch_stall = 1'b0; lw_stall = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1; count_clr = 1'b0;
        model_reset();
        // Reset state, including controls following inputs during reset
        step(0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0, 1, 1, 0);
        idle(2);
        // Load-use stall for one cycle, then quiet
        step(1, 0, 1, 0, 0, 1, 1, 0);
        idle(2);
        // Taken branch with operand hazard, then resolved branch
        step(1, 1, 0, 1, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1, 1, 1, 0);
        idle(1);
        // Data memory wait overrides load-use for 3 cycles
        step(1, 0, 1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 1, 0, 0);
        idle(2);
        // Watchdog: imem stall held until lock-up, then released, then reset mid-error
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 1, 1, 1);
        idle(2);
        step(0, 0, 0, 1, 0, 1, 1, 0);
        idle(1);
        // Saturation: 9 stall cycles broken every 3 so the watchdog stays quiet
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 0, 0, 0, 1, 1, 0);
            if (i % 3 == 2) idle(1);
        end
        idle(1);
        step(1, 0, 1, 0, 0, 1, 1, 1);
        idle(1);
        // Alternating stall / no-stall must never trip the watchdog
        for (int i = 0; i < 200; i++) begin
            if (i % 2 == 0) step(1, 0, 1, 0, 0, 1, 1, 0);
            else            step(1, 0, 0, 1, 0, 1, 1, 0);
        end
        // Randomised traffic with occasional clears and resets
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 6) != 0), ($urandom_range(0, 6) != 0),
                 ($urandom_range(0, 19) == 0));
        end
        // Let the monitor drain the scoreboard, with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
